uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning stalled-frame idle cycles before forced release (>=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports a_data/a_valid/a_last  input  8/1/1  requester A byte, valid, last-byte-of-frame flag.
REQ-005 SHALL have port a_ready  output  1  requester A byte accepted when a_valid&&a_ready.
REQ-006 SHALL have ports b_data/b_valid/b_last  input  8/1/1  requester B byte, valid, last flag.
REQ-007 SHALL have port b_ready  output  1  requester B accept.
REQ-008 SHALL have ports tx_data/tx_valid  output  8/1  byte stream toward the UART monitor transmit port.
REQ-009 SHALL have port tx_ready  input  1  UART monitor transmit ready.
REQ-010 SHALL have port grant  output  2  one-hot owner: 01=A, 10=B, 00=none.
REQ-011 SHALL have port timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-012 SHALL implement states IDLE and OWNED; the owner is held in a register.
REQ-013 IDLE: if exactly one of a_valid/b_valid is high, SHALL enter OWNED with that requester next cycle.
REQ-014 IDLE with both valid: SHALL grant the requester not served by the most recent completed or released frame; the pointer after reset favours A.
REQ-015 IDLE: tx_valid, a_ready and b_ready SHALL be 0; grant SHALL be 00.
REQ-016 OWNED: tx_data/tx_valid SHALL equal the owner's data/valid combinationally; owner ready SHALL equal tx_ready; non-owner ready SHALL be 0.
REQ-017 First byte latency: tx_valid SHALL rise exactly one cycle after the winning valid is sampled in IDLE.
REQ-018 OWNED SHALL persist across any number of bytes until a handshake (owner valid && tx_ready) with owner last=1; then return to IDLE next cycle and record owner in pointer.
REQ-019 A frame of one byte (last=1 on first byte) SHALL be legal; the frame holds OWNED for exactly one handshake.
REQ-020 Non-owner requests SHALL wait without loss; the arbiter SHALL never drop or reorder bytes within a frame.
REQ-021 After frame end, at least one IDLE cycle SHALL occur before the next grant.
REQ-022 grant SHALL be registered and reflect state/owner with zero additional latency.

Reset
REQ-023 On rst assertion, state SHALL go to IDLE immediately, mid-frame included; grant=00, pointer=A, timeout counter=0, timeout_err=0.
REQ-024 During reset, tx_valid, a_ready and b_ready SHALL be 0; the first grant SHALL be possible on the second clock edge after deassertion.

Configuration
REQ-025 Macro UART_ARB_TIMEOUT_EN SHALL gate the stall watchdog.
REQ-026 With the macro defined: the counter SHALL increment each OWNED cycle while owner valid=0, clear on any owner valid=1 cycle or on IDLE; on reaching TIMEOUT_CYCLES, force IDLE, set pointer to owner, and pulse timeout_err for one cycle.
REQ-027 Without the macro: no counter logic; timeout_err SHALL be constant 0; OWNED is left only via a last handshake or reset.

Verification
REQ-028 A sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_ready=1 -> tx_data 0x41..0x43 on consecutive cycles starting 1 cycle after a_valid; grant 01 then 00.
REQ-029 A and B both valid from reset, 2-byte frames each -> A frame completes, 1 IDLE cycle, B frame, then A again; no interleaving.
REQ-030 B owns the stream; tx_ready held low 20 cycles mid-frame -> b_ready=0 throughout, byte held stable, no timeout_err, frame resumes intact.
REQ-031 rst asserted during byte 2 of a 4-byte A frame -> grant=00 and tx_valid=0 in the same cycle; after release, B pending wins if pointer=A.
REQ-032 UART_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, A drops valid after byte 1 without last -> 8 cycles later timeout_err pulses once, grant=00, pending B granted next.
REQ-033 Build without UART_ARB_TIMEOUT_EN, same stall -> grant stays 01 for 1000 cycles, timeout_err=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester, frame-granular arbiter in front of a UART
// monitor transmit port. A requester keeps the stream from its first byte
// until the handshake of its last byte, so frames are never interleaved.
// When both requesters wait in IDLE, the one not served by the most recent
// frame wins; after reset requester A is favoured.
// Optional feature: define UART_ARB_TIMEOUT_EN to enable the stall watchdog
// that force-releases an owner whose valid stays low for TIMEOUT_CYCLES.
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a_data,
    input  logic       a_valid,
    input  logic       a_last,
    output logic       a_ready,
    input  logic [7:0] b_data,
    input  logic       b_valid,
    input  logic       b_last,
    output logic       b_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       timeout_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    state_t     state_q;
    logic       owner_q;        // current owner, meaningful only in OWNED
    logic       prio_b_q;       // 1: B wins a tie in IDLE, 0: A wins
    logic       armed_q;        // low for the first edge after reset
    logic       timeout_err_q;
    logic [1:0] grant_q;

    logic       own_valid_s;
    logic       own_last_s;
    logic       frame_end_s;
    logic       pick_b_s;
    logic       stall_expire_s;

    // Route the current owner's valid/last to the handshake logic
    always_comb begin
        own_valid_s = 1'b0;
        own_last_s  = 1'b0;
        if (owner_q == OWN_B) begin
            own_valid_s = b_valid;
            own_last_s  = b_last;
        end else begin
            own_valid_s = a_valid;
            own_last_s  = a_last;
        end
    end

    assign frame_end_s = (state_q == OWNED) && own_valid_s && tx_ready && own_last_s;
    assign pick_b_s    = b_valid && (!a_valid || prio_b_q);

    // Pass the granted requester through to the transmit port; grant_q is
    // the registered owner, so the mux adds no latency to byte transfer
    always_comb begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        case (grant_q)
            2'b01: begin
                tx_data  = a_data;
                tx_valid = a_valid;
                a_ready  = tx_ready;
            end
            2'b10: begin
                tx_data  = b_data;
                tx_valid = b_valid;
                b_ready  = tx_ready;
            end
            default: begin
                tx_data  = 8'h00;
                tx_valid = 1'b0;
            end
        endcase
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             stall_s;

    assign stall_s        = (state_q == OWNED) && !own_valid_s;
    assign stall_expire_s = stall_s && (stall_cnt_q == CNT_LAST);

    // Count consecutive owner-idle cycles; any owner valid or IDLE clears it
    always_comb begin
        stall_cnt_d = '0;
        if (stall_s && !stall_expire_s) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = '0;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign stall_expire_s = 1'b0;
`endif

    // Arbitration FSM: grant on a request in IDLE, release on last handshake
    // or watchdog expiry, and remember which side should win the next tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_A;
            prio_b_q      <= 1'b0;
            armed_q       <= 1'b0;
            grant_q       <= 2'b00;
            timeout_err_q <= 1'b0;
        end else begin
            armed_q       <= 1'b1;
            timeout_err_q <= stall_expire_s;
            case (state_q)
                IDLE: begin
                    if (armed_q && (a_valid || b_valid)) begin
                        state_q <= OWNED;
                        owner_q <= pick_b_s;
                        grant_q <= pick_b_s ? 2'b10 : 2'b01;
                    end else begin
                        grant_q <= 2'b00;
                    end
                end
                OWNED: begin
                    if (frame_end_s || stall_expire_s) begin
                        state_q  <= IDLE;
                        grant_q  <= 2'b00;
                        prio_b_q <= (owner_q == OWN_A);
                    end else begin
                        grant_q <= (owner_q == OWN_B) ? 2'b10 : 2'b01;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus a randomized run
// checked against a frame-level reference model with byte scoreboards.
module tb_uart_tx_arbiter;

    localparam int TO = 8;

    logic       clk;
    logic       rst;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_last;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_last;
    logic       b_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] grant;
    logic       timeout_err;

    int n_checks;
    int n_pass;

    logic [8:0] a_q[$];
    logic [8:0] b_q[$];
    int a_gap;
    int b_gap;
    bit rnd;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grant(grant), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation did not end, expected to finish");
        $fatal(1);
    end

    // One clock: capture handshakes, step past the edge, advance the sources.
    task automatic adv();
        logic af;
        logic bf;
        af = a_valid && a_ready;
        bf = b_valid && b_ready;
        @(posedge clk);
        #1;
        if (af && a_q.size() > 0) void'(a_q.pop_front());
        if (bf && b_q.size() > 0) void'(b_q.pop_front());
        if (a_valid && !af && a_q.size() > 0) begin
            a_valid = 1'b1;
        end else if (a_q.size() > 0 && (!rnd || a_gap >= 2 || $urandom_range(0, 3) != 0)) begin
            a_valid = 1'b1; a_gap = 0;
        end else begin
            a_valid = 1'b0; a_gap++;
        end
        if (b_valid && !bf && b_q.size() > 0) begin
            b_valid = 1'b1;
        end else if (b_q.size() > 0 && (!rnd || b_gap >= 2 || $urandom_range(0, 3) != 0)) begin
            b_valid = 1'b1; b_gap = 0;
        end else begin
            b_valid = 1'b0; b_gap++;
        end
        a_data = (a_q.size() > 0) ? a_q[0][7:0] : 8'h00;
        a_last = (a_q.size() > 0) ? a_q[0][8] : 1'b0;
        b_data = (b_q.size() > 0) ? b_q[0][7:0] : 8'h00;
        b_last = (b_q.size() > 0) ? b_q[0][8] : 1'b0;
        if (rnd) tx_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_q.delete(); b_q.delete();
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        a_data = 8'h00; b_data = 8'h00; tx_ready = 1'b0;
        a_gap = 0; b_gap = 0; rnd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_last = 1'b0; b_last = 1'b0;
        a_data = 8'h5A; b_data = 8'hA5; tx_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++; if (grant !== 2'b00) $display("FAIL reset_grant got=%b exp=00", grant); else n_pass++;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); else n_pass++;
        n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL reset_ready got=%b%b exp=00", a_ready, b_ready); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (grant !== 2'b00) $display("FAIL first_edge_no_grant got=%b exp=00", grant); else n_pass++;
        @(negedge clk);
        n_checks++; if (grant !== 2'b01) $display("FAIL second_edge_grant got=%b exp=01", grant); else n_pass++;
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) $display("FAIL second_edge_data got=%b/%h exp=1/5a", tx_valid, tx_data); else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [7:0] exp_d [0:2];
        exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43;
        do_reset(); tx_ready = 1'b1; adv();
        a_q.push_back({1'b0, 8'h41}); a_q.push_back({1'b0, 8'h42}); a_q.push_back({1'b1, 8'h43});
        adv();
        n_checks++; if (grant !== 2'b00 || tx_valid !== 1'b0) $display("FAIL single_pre_grant got=%b/%b exp=00/0", grant, tx_valid); else n_pass++;
        adv();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (grant !== 2'b01) $display("FAIL single_grant[%0d] got=%b exp=01", i, grant); else n_pass++;
            n_checks++; if (tx_valid !== 1'b1 || tx_data !== exp_d[i]) $display("FAIL single_data[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_d[i]); else n_pass++;
            n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL single_ready[%0d] got=%b%b exp=10", i, a_ready, b_ready); else n_pass++;
            adv();
        end
        n_checks++; if (grant !== 2'b00 || tx_valid !== 1'b0) $display("FAIL single_release got=%b/%b exp=00/0", grant, tx_valid); else n_pass++;
    endtask

    task automatic test_arbitration();
        logic [1:0] eg [0:9] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
        logic [7:0] ed [0:9] = '{8'h00, 8'h10, 8'h11, 8'h00, 8'h20, 8'h21, 8'h00, 8'h12, 8'h13, 8'h00};
        do_reset(); tx_ready = 1'b1; adv();
        a_q.push_back({1'b0, 8'h10}); a_q.push_back({1'b1, 8'h11});
        a_q.push_back({1'b0, 8'h12}); a_q.push_back({1'b1, 8'h13});
        b_q.push_back({1'b0, 8'h20}); b_q.push_back({1'b1, 8'h21});
        adv();
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (grant !== eg[i]) $display("FAIL arb_grant[%0d] got=%b exp=%b", i, grant, eg[i]); else n_pass++;
            if (eg[i] != 2'b00) begin
                n_checks++; if (tx_data !== ed[i]) $display("FAIL arb_data[%0d] got=%h exp=%h", i, tx_data, ed[i]); else n_pass++;
            end
            adv();
        end
    endtask

    task automatic test_stall();
        do_reset(); tx_ready = 1'b1; adv();
        b_q.push_back({1'b0, 8'h30}); b_q.push_back({1'b0, 8'h31});
        b_q.push_back({1'b0, 8'h32}); b_q.push_back({1'b1, 8'h33});
        adv(); adv();
        n_checks++; if (grant !== 2'b10 || tx_data !== 8'h30) $display("FAIL stall_start got=%b/%h exp=10/30", grant, tx_data); else n_pass++;
        adv(); adv();
        tx_ready = 1'b0; #1;
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (b_ready !== 1'b0) $display("FAIL stall_b_ready[%0d] got=%b exp=0", i, b_ready); else n_pass++;
            n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h32) $display("FAIL stall_hold[%0d] got=%b/%h exp=1/32", i, tx_valid, tx_data); else n_pass++;
            n_checks++; if (timeout_err !== 1'b0 || grant !== 2'b10) $display("FAIL stall_state[%0d] got=%b/%b exp=0/10", i, timeout_err, grant); else n_pass++;
            adv();
        end
        tx_ready = 1'b1; #1;
        n_checks++; if (b_ready !== 1'b1 || tx_data !== 8'h32) $display("FAIL stall_resume got=%b/%h exp=1/32", b_ready, tx_data); else n_pass++;
        adv();
        n_checks++; if (tx_data !== 8'h33 || grant !== 2'b10) $display("FAIL stall_last got=%h/%b exp=33/10", tx_data, grant); else n_pass++;
        adv();
        n_checks++; if (grant !== 2'b00) $display("FAIL stall_release got=%b exp=00", grant); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        do_reset(); tx_ready = 1'b1; adv();
        a_q.push_back({1'b0, 8'h40}); a_q.push_back({1'b0, 8'h41});
        a_q.push_back({1'b0, 8'h42}); a_q.push_back({1'b1, 8'h43});
        b_q.push_back({1'b0, 8'h50}); b_q.push_back({1'b1, 8'h51});
        adv(); adv();
        n_checks++; if (grant !== 2'b01 || tx_data !== 8'h40) $display("FAIL mid_first got=%b/%h exp=01/40", grant, tx_data); else n_pass++;
        adv();
        n_checks++; if (tx_data !== 8'h41) $display("FAIL mid_byte2 got=%h exp=41", tx_data); else n_pass++;
        rst = 1'b1; #1;
        n_checks++; if (grant !== 2'b00 || tx_valid !== 1'b0) $display("FAIL mid_rst_immediate got=%b/%b exp=00/0", grant, tx_valid); else n_pass++;
        n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL mid_rst_ready got=%b%b exp=00", a_ready, b_ready); else n_pass++;
        a_q.delete(); a_valid = 1'b0; a_last = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        adv();
        n_checks++; if (grant !== 2'b00) $display("FAIL mid_armed got=%b exp=00", grant); else n_pass++;
        adv();
        n_checks++; if (grant !== 2'b10 || tx_data !== 8'h50) $display("FAIL mid_b_wins got=%b/%h exp=10/50", grant, tx_data); else n_pass++;
        adv();
        n_checks++; if (tx_data !== 8'h51) $display("FAIL mid_b_last got=%h exp=51", tx_data); else n_pass++;
        adv();
        n_checks++; if (grant !== 2'b00) $display("FAIL mid_b_release got=%b exp=00", grant); else n_pass++;
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        do_reset(); tx_ready = 1'b1; adv();
        a_q.push_back({1'b0, 8'h60});
        b_q.push_back({1'b1, 8'h70});
        adv(); adv();
        n_checks++; if (grant !== 2'b01 || tx_data !== 8'h60) $display("FAIL to_owner got=%b/%h exp=01/60", grant, tx_data); else n_pass++;
        adv();
        k = 0;
        while (timeout_err !== 1'b1 && k < 20) begin
            adv();
            k++;
        end
        n_checks++; if (k != TO) $display("FAIL to_latency got=%0d exp=%0d", k, TO); else n_pass++;
        n_checks++; if (grant !== 2'b00) $display("FAIL to_release got=%b exp=00", grant); else n_pass++;
        adv();
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL to_single_pulse got=%b exp=0", timeout_err); else n_pass++;
        n_checks++; if (grant !== 2'b10 || tx_data !== 8'h70) $display("FAIL to_b_next got=%b/%h exp=10/70", grant, tx_data); else n_pass++;
        adv();
    endtask
`else
    task automatic test_timeout();
        int good;
        do_reset(); tx_ready = 1'b1; adv();
        a_q.push_back({1'b0, 8'h60});
        b_q.push_back({1'b1, 8'h70});
        adv(); adv();
        n_checks++; if (grant !== 2'b01 || tx_data !== 8'h60) $display("FAIL nto_owner got=%b/%h exp=01/60", grant, tx_data); else n_pass++;
        adv();
        good = 0;
        for (int i = 0; i < 1000; i++) begin
            if (grant === 2'b01 && timeout_err === 1'b0) good++;
            adv();
        end
        n_checks++; if (good != 1000) $display("FAIL nto_hold got=%0d exp=1000 cycles owned without error", good); else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [7:0] exp_a[$];
        logic [7:0] exp_b[$];
        int m_own;
        bit m_fav_b;
        int m_stall;
        bit m_err;
        bit err_n;
        int cyc;
        int len;
        logic [7:0] d;
        logic [1:0] eg;
        logic ev, ov, ol;
        do_reset(); tx_ready = 1'b1; adv();
        rnd = 1'b1;
        for (int f = 0; f < 10; f++) begin
            len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) begin
                d = 8'($urandom); a_q.push_back({(j == len - 1), d}); exp_a.push_back(d);
            end
            len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) begin
                d = 8'($urandom); b_q.push_back({(j == len - 1), d}); exp_b.push_back(d);
            end
        end
        m_own = 0; m_fav_b = 1'b0; m_stall = 0; m_err = 1'b0; cyc = 0;
        while ((exp_a.size() > 0 || exp_b.size() > 0 || m_own != 0) && cyc < 3000) begin
            eg = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
            ov = (m_own == 1) ? a_valid : (m_own == 2) ? b_valid : 1'b0;
            ol = (m_own == 1) ? a_last : (m_own == 2) ? b_last : 1'b0;
            ev = ov;
            n_checks++; if (grant !== eg) $display("FAIL rnd_grant@%0d got=%b exp=%b", cyc, grant, eg); else n_pass++;
            n_checks++; if (tx_valid !== ev) $display("FAIL rnd_tx_valid@%0d got=%b exp=%b", cyc, tx_valid, ev); else n_pass++;
            n_checks++; if (a_ready !== (m_own == 1 && tx_ready)) $display("FAIL rnd_a_ready@%0d got=%b exp=%b", cyc, a_ready, (m_own == 1 && tx_ready)); else n_pass++;
            n_checks++; if (b_ready !== (m_own == 2 && tx_ready)) $display("FAIL rnd_b_ready@%0d got=%b exp=%b", cyc, b_ready, (m_own == 2 && tx_ready)); else n_pass++;
            n_checks++; if (timeout_err !== m_err) $display("FAIL rnd_timeout_err@%0d got=%b exp=%b", cyc, timeout_err, m_err); else n_pass++;
            if (ov && tx_ready) begin
                if (m_own == 1 && exp_a.size() > 0) begin
                    n_checks++; if (tx_data !== exp_a[0]) $display("FAIL rnd_a_byte@%0d got=%h exp=%h", cyc, tx_data, exp_a[0]); else n_pass++;
                    void'(exp_a.pop_front());
                end else if (m_own == 2 && exp_b.size() > 0) begin
                    n_checks++; if (tx_data !== exp_b[0]) $display("FAIL rnd_b_byte@%0d got=%h exp=%h", cyc, tx_data, exp_b[0]); else n_pass++;
                    void'(exp_b.pop_front());
                end
            end
            err_n = 1'b0;
            if (m_own == 0) begin
                m_stall = 0;
                if (a_valid || b_valid) m_own = (b_valid && (!a_valid || m_fav_b)) ? 2 : 1;
            end else if (ov && tx_ready && ol) begin
                m_fav_b = (m_own == 1); m_own = 0; m_stall = 0;
            end else if (!ov) begin
                m_stall++;
`ifdef UART_ARB_TIMEOUT_EN
                if (m_stall >= TO) begin
                    m_fav_b = (m_own == 1); m_own = 0; m_stall = 0; err_n = 1'b1;
                end
`endif
            end else begin
                m_stall = 0;
            end
            m_err = err_n;
            adv();
            cyc++;
        end
        rnd = 1'b0;
        n_checks++; if (cyc >= 3000) $display("FAIL rnd_budget got=%0d cycles exp<3000", cyc); else n_pass++;
        n_checks++; if (exp_a.size() != 0 || exp_b.size() != 0) $display("FAIL rnd_drain got=%0d/%0d bytes left exp=0/0", exp_a.size(), exp_b.size()); else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        a_data = 8'h00; b_data = 8'h00; tx_ready = 1'b0;
        a_gap = 0; b_gap = 0; rnd = 1'b0;
        test_reset();
        test_single_frame();
        test_arbitration();
        test_stall();
        test_reset_midframe();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
